// File: rtl/master_cmd_seq.sv
// Command sequencer in front of the PCI master: queues host single-word commands,
// issues them over start/ack, re-issues on retry and reports status/read data.
module master_cmd_seq #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 7,
  parameter int RETRY_GAP = 2
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     cmd_wr,
  input  logic                     cmd_dir,
  input  logic [31:0]              cmd_addr,
  input  logic [31:0]              cmd_wdata,
  output logic                     cmd_full,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     cmd_overflow,
  output logic                     mst_start,
  output logic                     mst_dir,
  output logic [31:0]              mst_addr,
  output logic [31:0]              mst_wdata,
  input  logic                     mst_ack,
  input  logic                     mst_done,
  input  logic                     mst_fatal,
  input  logic                     mst_retry,
  input  logic [31:0]              mst_rdata,
  output logic                     res_valid,
  output logic [1:0]               res_status,
  output logic [31:0]              res_rdata,
  input  logic                     res_ack,
  output logic                     busy,
  output logic                     halted,
  output logic [2:0]               o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_RESULT = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t r_state, w_state_nxt;

  logic          r_dir_mem   [DEPTH];
  logic [31:0]   r_addr_mem  [DEPTH];
  logic [31:0]   r_wdata_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full, r_overflow;
  logic          r_start, r_dir;
  logic [31:0]   r_addr, r_wdata;
  logic          r_res_valid;
  logic [1:0]    r_res_status;
  logic [31:0]   r_res_rdata;
  logic          r_busy, r_halted;
  logic [3:0]    r_retry_cnt;
  logic [GW-1:0] r_gap_cnt;

  logic          w_push, w_pop;
  logic [CW-1:0] w_count_nxt;

  // Fullness is judged on registered occupancy, so a pop cannot rescue a push made while full.
  assign w_push      = cmd_wr && !r_full;
  assign w_pop       = (r_state == S_RESULT) && res_ack;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (r_count != '0) w_state_nxt = S_ISSUE;
      S_ISSUE:  if (mst_ack) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mst_done) begin
          if (!mst_fatal && mst_retry && (r_retry_cnt < RETRY_LIM)) w_state_nxt = S_GAP;
          else                                                    w_state_nxt = S_RESULT;
        end
      end
      S_GAP:    if (r_gap_cnt == GAP_LAST) w_state_nxt = S_ISSUE;
      S_RESULT: if (res_ack) w_state_nxt = (r_res_status == 2'b10) ? S_HALT : S_IDLE;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_dir_mem[r_wr_ptr]   <= cmd_dir;
      r_addr_mem[r_wr_ptr]  <= cmd_addr;
      r_wdata_mem[r_wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
      r_start      <= 1'b0;
      r_dir        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_res_valid  <= 1'b0;
      r_res_status <= 2'b00;
      r_res_rdata  <= '0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_retry_cnt  <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_start     <= (w_state_nxt == S_ISSUE);
      r_res_valid <= (w_state_nxt == S_RESULT);
      r_busy      <= (w_state_nxt inside {S_ISSUE, S_WAIT, S_GAP, S_RESULT});
      r_halted    <= (w_state_nxt == S_HALT);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (cmd_wr && r_full) r_overflow <= 1'b1;

      // The head is read once per command; retries reuse the latched copy.
      if (r_state == S_IDLE && r_count != '0) begin
        r_dir       <= r_dir_mem[r_rd_ptr];
        r_addr      <= r_addr_mem[r_rd_ptr];
        r_wdata     <= r_wdata_mem[r_rd_ptr];
        r_retry_cnt <= '0;
      end

      if (r_state == S_WAIT && mst_done) begin
        if (mst_fatal) begin
          r_res_status <= 2'b10;
          r_res_rdata  <= '0;
        end else if (mst_retry && (r_retry_cnt < RETRY_LIM)) begin
          r_retry_cnt <= r_retry_cnt + 1'b1;
          r_gap_cnt   <= '0;
        end else if (mst_retry) begin
          r_res_status <= 2'b01;
          r_res_rdata  <= '0;
        end else begin
          r_res_status <= 2'b00;
          r_res_rdata  <= r_dir ? 32'h0 : mst_rdata;
        end
      end

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  assign cmd_full     = r_full;
  assign cmd_count    = r_count;
  assign cmd_overflow = r_overflow;
  assign mst_start    = r_start;
  assign mst_dir      = r_dir;
  assign mst_addr     = r_addr;
  assign mst_wdata    = r_wdata;
  assign res_valid    = r_res_valid;
  assign res_status   = r_res_status;
  assign res_rdata    = r_res_rdata;
  assign busy         = r_busy;
  assign halted       = r_halted;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_master_cmd_seq.sv
// Directed bench for master_cmd_seq: scripted master responses, result scoreboard
// with hand-computed expected status/read data.
module tb_master_cmd_seq;
  localparam int DEPTH     = 4;
  localparam int MAX_RETRY = 7;
  localparam int RETRY_GAP = 2;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        cmd_wr, cmd_dir;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_full;
  logic [2:0]  cmd_count;
  logic        cmd_overflow;
  logic        mst_start, mst_dir;
  logic [31:0] mst_addr, mst_wdata;
  logic        mst_ack, mst_done, mst_fatal, mst_retry;
  logic [31:0] mst_rdata;
  logic        res_valid;
  logic [1:0]  res_status;
  logic [31:0] res_rdata;
  logic        res_ack;
  logic        busy, halted;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];

  master_cmd_seq #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .cmd_wr(cmd_wr), .cmd_dir(cmd_dir), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_full(cmd_full), .cmd_count(cmd_count), .cmd_overflow(cmd_overflow),
    .mst_start(mst_start), .mst_dir(mst_dir), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_ack(mst_ack), .mst_done(mst_done), .mst_fatal(mst_fatal), .mst_retry(mst_retry),
    .mst_rdata(mst_rdata),
    .res_valid(res_valid), .res_status(res_status), .res_rdata(res_rdata), .res_ack(res_ack),
    .busy(busy), .halted(halted), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push(input logic dir, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_wr    = 1'b1;
    cmd_dir   = dir;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_wr    = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int cycles);
    cycles = 0;
    while (mst_start !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    check({tag, "_start"}, 32'(mst_start), 32'd1);
  endtask

  task automatic serve(input int ack_delay, input logic retry, input logic fatal,
                       input logic [31:0] rdata);
    repeat (ack_delay) tick();
    mst_ack = 1'b1;
    tick();
    mst_ack   = 1'b0;
    mst_done  = 1'b1;
    mst_retry = retry;
    mst_fatal = fatal;
    mst_rdata = rdata;
    tick();
    mst_done  = 1'b0;
    mst_retry = 1'b0;
    mst_fatal = 1'b0;
    mst_rdata = 32'h0;
  endtask

  // scoreboard: compares the presented result with the head of exp_q, then consumes it
  task automatic take_result(input string tag);
    int n = 0;
    logic [33:0] e;
    while (res_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    check({tag, "_status"}, 32'(res_status), 32'(e[33:32]));
    check({tag, "_rdata"}, res_rdata, e[31:0]);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check({tag, "_valid_clr"}, 32'(res_valid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"},  32'(mst_start), 32'd0);
    check({tag, "_dir"},    32'(mst_dir), 32'd0);
    check({tag, "_addr"},   mst_addr, 32'h0);
    check({tag, "_wdata"},  mst_wdata, 32'h0);
    check({tag, "_rvalid"}, 32'(res_valid), 32'd0);
    check({tag, "_rstat"},  32'(res_status), 32'd0);
    check({tag, "_rdata"},  res_rdata, 32'h0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_count"},  32'(cmd_count), 32'd0);
    check({tag, "_full"},   32'(cmd_full), 32'd0);
    check({tag, "_ovf"},    32'(cmd_overflow), 32'd0);
  endtask

  initial begin
    int cyc;
    int issues;
    logic saw_start;

    reset_n = 1'b0; cmd_wr = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    mst_ack = 1'b0; mst_done = 1'b0; mst_fatal = 1'b0; mst_retry = 1'b0;
    mst_rdata = '0; res_ack = 1'b0;
    do_reset();
    check_reset_values("init");

    // write then read
    push(1'b1, 32'h0000_1000, 32'hA5A5_5A5A);
    check("t1_count1", 32'(cmd_count), 32'd1);
    check("t1_start_early", 32'(mst_start), 32'd0);
    push(1'b0, 32'h0000_1004, 32'h0);
    check("t1_start_rise", 32'(mst_start), 32'd1);
    check("t1_dir", 32'(mst_dir), 32'd1);
    check("t1_addr", mst_addr, 32'h0000_1000);
    check("t1_wdata", mst_wdata, 32'hA5A5_5A5A);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_count2", 32'(cmd_count), 32'd2);
    serve(3, 1'b0, 1'b0, 32'hDEAD_BEEF);
    exp_q.push_back({2'b00, 32'h0});
    take_result("t1_wr");
    wait_start("t1_rd", cyc);
    check("t1_rd_addr", mst_addr, 32'h0000_1004);
    check("t1_rd_dir", 32'(mst_dir), 32'd0);
    serve(3, 1'b0, 1'b0, 32'h1234_5678);
    exp_q.push_back({2'b00, 32'h1234_5678});
    take_result("t1_rd");
    tick();
    check("t1_count0", 32'(cmd_count), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // retry recovery: two retries, then clean completion
    push(1'b0, 32'h0000_2000, 32'h0);
    wait_start("t2_first", cyc);
    for (int i = 0; i < 2; i++) begin
      serve(1, 1'b1, 1'b0, 32'h0);
      check("t2_start_drop", 32'(mst_start), 32'd0);
      wait_start("t2_reissue", cyc);
      check("t2_gap_cycles", cyc, RETRY_GAP);
      check("t2_addr", mst_addr, 32'h0000_2000);
    end
    serve(0, 1'b0, 1'b0, 32'hCAFE_0001);
    exp_q.push_back({2'b00, 32'hCAFE_0001});
    take_result("t2");

    // retry exhaustion, then next entry issued
    push(1'b1, 32'h0000_3000, 32'h0000_0011);
    push(1'b0, 32'h0000_3004, 32'h0);
    issues = 0;
    for (int i = 0; i < MAX_RETRY + 1; i++) begin
      wait_start("t3_issue", cyc);
      if (mst_start === 1'b1) issues++;
      check("t3_addr", mst_addr, 32'h0000_3000);
      serve(1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    end
    check("t3_issue_count", issues, MAX_RETRY + 1);
    check("t3_no_extra_start", 32'(mst_start), 32'd0);
    exp_q.push_back({2'b01, 32'h0});
    take_result("t3_exh");
    wait_start("t3_next", cyc);
    check("t3_next_addr", mst_addr, 32'h0000_3004);
    serve(0, 1'b0, 1'b0, 32'h55AA_55AA);
    exp_q.push_back({2'b00, 32'h55AA_55AA});
    take_result("t3_next");

    // fatal with retry also set: fatal wins, then halt
    push(1'b1, 32'h0000_4000, 32'h0000_0044);
    push(1'b0, 32'h0000_4004, 32'h0);
    wait_start("t4", cyc);
    serve(0, 1'b1, 1'b1, 32'h7777_7777);
    exp_q.push_back({2'b10, 32'h0});
    take_result("t4_fatal");
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_count", 32'(cmd_count), 32'd1);
    saw_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mst_start !== 1'b0) saw_start = 1'b1;
    end
    check("t4_no_issue", 32'(saw_start), 32'd0);
    check("t4_count_hold", 32'(cmd_count), 32'd1);
    push(1'b0, 32'h0000_4008, 32'h0);
    check("t4_halt_push", 32'(cmd_count), 32'd2);
    check("t4_halt_still", 32'(halted), 32'd1);

    // FIFO boundary with stalled master
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 32'h0000_5000 + 32'(4 * i), 32'h0);
      if (i == 3) check("t5_ovf_early", 32'(cmd_overflow), 32'd0);
    end
    check("t5_count", 32'(cmd_count), 32'd4);
    check("t5_full", 32'(cmd_full), 32'd1);
    check("t5_ovf", 32'(cmd_overflow), 32'd1);
    repeat (3) tick();
    check("t5_stall_start", 32'(mst_start), 32'd1);
    check("t5_head", mst_addr, 32'h0000_5000);
    serve(0, 1'b0, 1'b0, 32'h0000_00B0);
    exp_q.push_back({2'b00, 32'h0000_00B0});
    take_result("t5_r0");
    check("t5_count3", 32'(cmd_count), 32'd3);
    check("t5_not_full", 32'(cmd_full), 32'd0);
    wait_start("t5_r1", cyc);
    check("t5_r1_addr", mst_addr, 32'h0000_5004);
    serve(0, 1'b0, 1'b0, 32'h0000_00B1);
    exp_q.push_back({2'b00, 32'h0000_00B1});
    cmd_wr = 1'b1; cmd_dir = 1'b0; cmd_addr = 32'h0000_5100; cmd_wdata = 32'h0;
    take_result("t5_r1");
    cmd_wr = 1'b0;
    check("t5_pop_push", 32'(cmd_count), 32'd3);
    check("t5_ovf_sticky", 32'(cmd_overflow), 32'd1);
    wait_start("t5_r2", cyc);
    check("t5_r2_addr", mst_addr, 32'h0000_5008);
    serve(0, 1'b0, 1'b0, 32'h0000_00B2);
    exp_q.push_back({2'b00, 32'h0000_00B2});
    take_result("t5_r2");
    wait_start("t5_r3", cyc);
    check("t5_r3_addr", mst_addr, 32'h0000_500C);
    serve(0, 1'b0, 1'b0, 32'h0000_00B3);
    exp_q.push_back({2'b00, 32'h0000_00B3});
    take_result("t5_r3");
    wait_start("t5_r4", cyc);
    check("t5_r4_addr", mst_addr, 32'h0000_5100);
    serve(0, 1'b0, 1'b0, 32'h0000_00B4);
    exp_q.push_back({2'b00, 32'h0000_00B4});
    take_result("t5_r4");
    tick();
    check("t5_empty", 32'(cmd_count), 32'd0);

    // reset while waiting for completion
    do_reset();
    push(1'b1, 32'h0000_6000, 32'h0000_0066);
    push(1'b0, 32'h0000_6004, 32'h0);
    wait_start("t6", cyc);
    mst_ack = 1'b1;
    tick();
    mst_ack = 1'b0;
    check("t6_in_wait", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_reset_values("t6_rst");
    mst_done = 1'b1; mst_rdata = 32'h0000_0099;
    tick();
    mst_done = 1'b0; mst_rdata = 32'h0;
    tick();
    tick();
    check("t6_no_result", 32'(res_valid), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_count", 32'(cmd_count), 32'd0);
    check("t6_no_start", 32'(mst_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/master_cmd_seq.md
Name: master_cmd_seq

Overview:
- Command sequencer directly upstream of the PCI master user-side logic.
- Buffers host-issued single-word transactions (direction, address, write data) in a small FIFO. Presents them one at a time to the master stage over a start/ack handshake.
- Tracks completion status (normal, retry, fatal), re-issues retried transactions up to a limit, and returns read data and status to the host through a result handshake.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- MAX_RETRY, 7, re-issues allowed after a retry termination before giving up; range 0..15.
- RETRY_GAP, 2, idle cycles between a retry termination and re-issue; minimum 1.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on CLK rising edge.
- cmd_wr  input  1  host push strobe; one command per cycle.
- cmd_dir  input  1  1 = write, 0 = read (same encoding as master m_wrdn).
- cmd_addr  input  32  transaction address.
- cmd_wdata  input  32  write data; ignored for reads.
- cmd_full  output  1  FIFO holds DEPTH entries.
- cmd_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- cmd_overflow  output  1  sticky; set when cmd_wr is seen while cmd_full.
- mst_start  output  1  transaction request to the master stage.
- mst_dir  output  1  direction of the current transaction.
- mst_addr  output  32  address of the current transaction.
- mst_wdata  output  32  write data of the current transaction.
- mst_ack  input  1  master accepted the request.
- mst_done  input  1  single-cycle completion pulse from the master.
- mst_fatal  input  1  qualifies mst_done: master/target abort.
- mst_retry  input  1  qualifies mst_done: target retry/disconnect without data.
- mst_rdata  input  32  read data; valid with mst_done.
- res_valid  output  1  result available.
- res_status  output  2  00 ok, 01 retry limit exhausted, 10 fatal.
- res_rdata  output  32  read data; 0 for writes and for non-ok status.
- res_ack  input  1  host consumes the result.
- busy  output  1  state is not IDLE or HALT.
- halted  output  1  state is HALT.

Behaviour:
- Reset (reset_n low at an edge):
  - FIFO emptied; cmd_count=0, cmd_full=0, cmd_overflow=0.
  - mst_start=0, mst_dir=0, mst_addr=0, mst_wdata=0.
  - res_valid=0, res_status=00, res_rdata=0.
  - busy=0, halted=0, state IDLE, retry counter 0.
  - Reset mid-transaction abandons the transaction; a later mst_done is ignored because the state is IDLE.
- All outputs are registered.
- FIFO:
  - Push when cmd_wr and not cmd_full, using registered occupancy. A push while full is dropped and sets cmd_overflow, even if a pop occurs in the same cycle.
  - Pop occurs only on the RESULT exit (res_ack seen).
  - Simultaneous push and pop when not full leaves cmd_count unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, ISSUE, WAIT, GAP, RESULT, HALT.
- IDLE:
  - If cmd_count != 0: load the FIFO head into mst_dir, mst_addr and mst_wdata, clear the retry counter, and go to ISSUE.
  - Latency: cmd_wr sampled at edge N -> count=1 after N -> ISSUE and mst_start=1 after edge N+1.
- ISSUE:
  - mst_start=1 and held until mst_ack is seen at an edge; then mst_start=0 and go to WAIT.
  - mst_dir, mst_addr and mst_wdata stay stable from ISSUE through RESULT.
- WAIT: on mst_done at an edge:
  - If mst_fatal (takes priority over mst_retry): res_status=10, res_rdata=0, res_valid=1, go to RESULT.
  - Else if mst_retry and retry counter < MAX_RETRY: increment the counter, go to GAP.
  - Else if mst_retry and counter == MAX_RETRY: res_status=01, res_rdata=0, go to RESULT.
  - Else: res_status=00; res_rdata = mst_rdata if mst_dir=0, else 0; go to RESULT.
  - mst_done outside WAIT is ignored.
- GAP: count RETRY_GAP cycles, then go to ISSUE with mst_start=1. The FIFO head is not re-read.
- RESULT:
  - res_valid=1 and res_status/res_rdata are held until res_ack is seen.
  - On res_ack: res_valid=0, pop the FIFO, then go to HALT if res_status=10, otherwise go to IDLE.
- HALT:
  - Terminal until reset. halted=1, mst_start=0.
  - The FIFO still accepts pushes up to full; nothing is issued.
- busy=1 in ISSUE, WAIT, GAP and RESULT.

Test Plan:
- Write then read: push (dir=1, addr 0x0000_1000, wdata 0xA5A5_5A5A), then push (dir=0, addr 0x0000_1004). Master acks after 3 cycles; done with rdata 0x1234_5678 on the read. Required: mst_start rises 2 edges after the first push; results are 00/0x0 then 00/0x1234_5678, in order.
- Retry recovery: first two mst_done pulses carry mst_retry, the third is clean. Required: mst_start re-asserts exactly RETRY_GAP=2 cycles after each retry; address is unchanged; result status 00.
- Retry exhaustion: MAX_RETRY=7 with every done carrying retry. Required: 8 issues total, then res_status=01 and res_rdata=0; the next FIFO entry is issued after res_ack.
- Fatal: done with mst_fatal=1 and mst_retry=1 together. Required: status 10; after res_ack halted=1; a queued second command is never issued; cmd_count stays 1.
- FIFO boundary: 5 pushes in consecutive cycles with the master stalled (mst_ack=0). Required: cmd_count=4, cmd_full=1, cmd_overflow=1, fifth command lost. Then pop and push in the same cycle at count 3: count stays 3.
- Reset mid-WAIT: assert reset_n=0 for 1 edge, then pulse mst_done. Required: all outputs at reset values, no result produced, cmd_count=0.
